// File: rtl/conv_mem_arb_if.sv
// conv_mem_arb_if: requester and memory-side signals of the conv/pool memory arbiter
interface conv_mem_arb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
);
  logic              req_0, lock_0, we_0, gnt_0, rvalid_0;
  logic [2:0]        sel_0;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] wdata_0, rdata_0;
  logic              req_1, lock_1, we_1, gnt_1, rvalid_1;
  logic [2:0]        sel_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_1, rdata_1;
  logic              cwr, crd;
  logic [2:0]        csel;
  logic [ADDR_W-1:0] caddr_wr, caddr_rd;
  logic [DATA_W-1:0] cdata_wr, cdata_rd;
  modport slave (
    input  req_0, lock_0, we_0, sel_0, addr_0, wdata_0,
    input  req_1, lock_1, we_1, sel_1, addr_1, wdata_1,
    input  cdata_rd,
    output gnt_0, rvalid_0, rdata_0, gnt_1, rvalid_1, rdata_1,
    output cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
  );
  modport master (
    output req_0, lock_0, we_0, sel_0, addr_0, wdata_0,
    output req_1, lock_1, we_1, sel_1, addr_1, wdata_1,
    output cdata_rd,
    input  gnt_0, rvalid_0, rdata_0, gnt_1, rvalid_1, rdata_1,
    input  cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
  );
endinterface

// File: rtl/conv_mem_arb.sv
// conv_mem_arb: two-requester round-robin memory arbiter with lock and registered command stage
module conv_mem_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
) (
  input logic clk,
  input logic reset,
  conv_mem_arb_if.slave bus
);
  typedef enum logic [1:0] {FREE, OWN0, OWN1} own_t;
  own_t              own;
  logic              rr, tag, g0, g1, xfer, idx, lk, we;
  logic [3:0]        lock_cnt;
  logic [2:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  // grant from requests, lock owner and last-granted pointer; the owner blocks the other side even when idle
  always_comb begin
    g0 = !reset && bus.req_0 && (own == OWN0 || (own == FREE && (!bus.req_1 || rr)));
    g1 = !reset && bus.req_1 && (own == OWN1 || (own == FREE && (!bus.req_0 || !rr)));
    xfer = g0 || g1;
    idx = g1;
    lk = idx ? bus.lock_1 : bus.lock_0;
    we = idx ? bus.we_1 : bus.we_0;
    sel = idx ? bus.sel_1 : bus.sel_0;
    addr = idx ? bus.addr_1 : bus.addr_0;
    wdata = idx ? bus.wdata_1 : bus.wdata_0;
  end
  assign bus.gnt_0 = g0;
  assign bus.gnt_1 = g1;
  // command stage, tagged read return, round-robin pointer and lock ownership with a 16-transfer cap
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cwr <= 1'b0;
      bus.crd <= 1'b0;
      bus.csel <= '0;
      bus.caddr_wr <= '0;
      bus.caddr_rd <= '0;
      bus.cdata_wr <= '0;
      bus.rvalid_0 <= 1'b0;
      bus.rvalid_1 <= 1'b0;
      bus.rdata_0 <= '0;
      bus.rdata_1 <= '0;
      rr <= 1'b1;
      tag <= 1'b0;
      own <= FREE;
      lock_cnt <= '0;
    end else begin
      bus.cwr <= xfer && we;
      bus.crd <= xfer && !we;
      bus.rvalid_0 <= bus.crd && !tag;
      bus.rvalid_1 <= bus.crd && tag;
      if (bus.crd && !tag) bus.rdata_0 <= bus.cdata_rd;
      if (bus.crd && tag) bus.rdata_1 <= bus.cdata_rd;
      if (xfer) begin
        bus.csel <= sel;
        bus.caddr_wr <= addr;
        bus.caddr_rd <= addr;
        bus.cdata_wr <= wdata;
        tag <= idx;
        rr <= idx;
        own <= (lk && lock_cnt != 4'd15) ? (idx ? OWN1 : OWN0) : FREE;
        lock_cnt <= (lk && lock_cnt != 4'd15) ? lock_cnt + 4'd1 : 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mem_arb.sv
// tb_conv_mem_arb: scoreboard bench for the conv/pool memory arbiter
module tb_conv_mem_arb;
  localparam int AW = 12;
  localparam int DW = 20;
  typedef struct {
    int          due;
    logic        we;
    logic [2:0]  sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;
  typedef struct {
    int          due;
    logic        tag;
    logic [DW-1:0] data;
  } rd_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  cmd_t cmd_q[$];
  rd_t rd_q[$];
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] exp_mem [0:4095];
  conv_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  conv_mem_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory model: write lands at the edge after cwr, read data valid during the crd cycle
  always @(posedge clk) if (bus.cwr) mem[bus.caddr_wr] <= bus.cdata_wr;
  assign bus.cdata_rd = bus.crd ? mem[bus.caddr_rd] : '0;
  // scoreboard monitor: commands and read returns checked when due, idle otherwise
  always @(negedge clk) begin
    cmd_t c;
    rd_t r;
    n_chk++;
    if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
      c = cmd_q.pop_front();
      if ({bus.cwr, bus.crd, bus.csel, bus.caddr_wr, bus.caddr_rd, bus.cdata_wr} !==
          {c.we, !c.we, c.sel, c.addr, c.addr, c.data}) begin
        n_fail++;
        $display("FAIL cmd cyc=%0d got wr=%b rd=%b sel=%b aw=%h ar=%h d=%h want wr=%b sel=%b a=%h d=%h",
                 cyc, bus.cwr, bus.crd, bus.csel, bus.caddr_wr, bus.caddr_rd, bus.cdata_wr, c.we, c.sel, c.addr, c.data);
      end
    end else if (bus.cwr !== 1'b0 || bus.crd !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_strobe cyc=%0d got cwr=%b crd=%b want 0 0", cyc, bus.cwr, bus.crd);
    end
    n_chk++;
    if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
      r = rd_q.pop_front();
      if ({bus.rvalid_0, bus.rvalid_1} !== {!r.tag, r.tag} || (r.tag ? bus.rdata_1 : bus.rdata_0) !== r.data) begin
        n_fail++;
        $display("FAIL rd_return cyc=%0d got v0=%b v1=%b d0=%h d1=%h want tag=%0d data=%h",
                 cyc, bus.rvalid_0, bus.rvalid_1, bus.rdata_0, bus.rdata_1, r.tag, r.data);
      end
    end else if (bus.rvalid_0 !== 1'b0 || bus.rvalid_1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_rvalid cyc=%0d got v0=%b v1=%b want 0 0", cyc, bus.rvalid_0, bus.rvalid_1);
    end
  end
  task automatic set_req(input int i, input logic r, input logic l, input logic w, input logic [2:0] s,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin
      bus.req_0 = r; bus.lock_0 = l; bus.we_0 = w; bus.sel_0 = s; bus.addr_0 = a; bus.wdata_0 = d;
    end else begin
      bus.req_1 = r; bus.lock_1 = l; bus.we_1 = w; bus.sel_1 = s; bus.addr_1 = a; bus.wdata_1 = d;
    end
  endtask
  task automatic idle();
    set_req(0, 0, 0, 0, 3'b000, '0, '0);
    set_req(1, 0, 0, 0, 3'b000, '0, '0);
  endtask
  task automatic tick(input int g);
    logic w;
    logic [2:0] s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (g >= 0) begin
      w = g ? bus.we_1 : bus.we_0;
      s = g ? bus.sel_1 : bus.sel_0;
      a = g ? bus.addr_1 : bus.addr_0;
      d = g ? bus.wdata_1 : bus.wdata_0;
      cmd_q.push_back('{due: cyc + 1, we: w, sel: s, addr: a, data: d});
      if (w) exp_mem[a] = d;
      else rd_q.push_back('{due: cyc + 2, tag: g[0], data: exp_mem[a]});
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1, 0, 1, 3'b001, 12'h001, 20'h11111);
    set_req(1, 1, 0, 0, 3'b011, 12'h002, 20'h22222);
    #1;
    n_chk++;
    if ({bus.gnt_0, bus.gnt_1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt got %b%b want 00", bus.gnt_0, bus.gnt_1);
    end
    tick(-1);
    tick(-1);
    n_chk++;
    if ({bus.csel, bus.caddr_wr, bus.caddr_rd, bus.cdata_wr, bus.rdata_0, bus.rdata_1} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs got sel=%b aw=%h ar=%h dw=%h r0=%h r1=%h want all 0",
               bus.csel, bus.caddr_wr, bus.caddr_rd, bus.cdata_wr, bus.rdata_0, bus.rdata_1);
    end
    idle();
    reset = 1'b0;
    tick(-1);
  endtask
  task automatic test_single_write();
    set_req(0, 1, 0, 1, 3'b001, 12'h005, 20'h0ABCD);
    #1;
    n_chk++;
    if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin
      n_fail++; $display("FAIL write_gnt got %b%b want 10", bus.gnt_0, bus.gnt_1);
    end
    tick(0);
    idle();
  endtask
  task automatic test_read_latency();
    set_req(1, 1, 0, 0, 3'b001, 12'h005, '0);
    #1;
    n_chk++;
    if ({bus.gnt_0, bus.gnt_1} !== 2'b01) begin
      n_fail++; $display("FAIL read_gnt got %b%b want 01", bus.gnt_0, bus.gnt_1);
    end
    tick(1);
    idle();
    n_chk++;
    if (bus.crd !== 1'b1 || bus.rvalid_1 !== 1'b0) begin
      n_fail++; $display("FAIL read_k got crd=%b rv1=%b want 1 0", bus.crd, bus.rvalid_1);
    end
    tick(-1);
    n_chk++;
    if (bus.rvalid_1 !== 1'b1 || bus.rdata_1 !== 20'h0ABCD || bus.rvalid_0 !== 1'b0) begin
      n_fail++;
      $display("FAIL read_k1 got rv1=%b rd1=%h rv0=%b want 1 0abcd 0", bus.rvalid_1, bus.rdata_1, bus.rvalid_0);
    end
    tick(-1);
    n_chk++;
    if (bus.rvalid_1 !== 1'b0 || bus.rdata_1 !== 20'h0ABCD) begin
      n_fail++; $display("FAIL read_k2 got rv1=%b rd1=%h want 0 0abcd", bus.rvalid_1, bus.rdata_1);
    end
  endtask
  task automatic test_wr_then_rd();
    set_req(0, 1, 0, 1, 3'b011, 12'h03C, 20'h5A5A5);
    #1;
    n_chk++;
    if (bus.gnt_0 !== 1'b1) begin
      n_fail++; $display("FAIL wr_rd_gnt_w got %b want 1", bus.gnt_0);
    end
    tick(0);
    set_req(0, 1, 0, 0, 3'b011, 12'h03C, '0);
    #1;
    n_chk++;
    if (bus.gnt_0 !== 1'b1) begin
      n_fail++; $display("FAIL wr_rd_gnt_r got %b want 1", bus.gnt_0);
    end
    tick(0);
    idle();
    tick(-1);
    n_chk++;
    if (bus.rdata_0 !== 20'h5A5A5) begin
      n_fail++; $display("FAIL wr_rd_data got %h want 5a5a5", bus.rdata_0);
    end
    tick(-1);
  endtask
  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    reset = 1'b1;
    tick(-1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, 0, 3'b001, 12'h010 + AW'(i), '0);
      set_req(1, 1, 0, 0, 3'b011, 12'h020 + AW'(i), '0);
      #1;
      n_chk++;
      if ({bus.gnt_0, bus.gnt_1} !== {exp_g[i] == 0, exp_g[i] == 1}) begin
        n_fail++; $display("FAIL rr_gnt[%0d] got %b%b want idx %0d", i, bus.gnt_0, bus.gnt_1, exp_g[i]);
      end
      tick(exp_g[i]);
    end
    idle();
    tick(-1);
    tick(-1);
  endtask
  task automatic test_lock();
    int exp_g[7] = '{0, 1, 1, -1, 1, 1, 0};
    logic r1[7] = '{1, 1, 1, 0, 1, 1, 0};
    logic l1[7] = '{1, 1, 1, 1, 1, 0, 0};
    set_req(0, 1, 0, 0, 3'b001, 12'h300, '0);
    for (int i = 0; i < 7; i++) begin
      set_req(1, r1[i], l1[i], 0, 3'b011, 12'h040 + AW'(i), '0);
      #1;
      n_chk++;
      if ({bus.gnt_0, bus.gnt_1} !== {exp_g[i] == 0, exp_g[i] == 1}) begin
        n_fail++; $display("FAIL lock_gnt[%0d] got %b%b want idx %0d", i, bus.gnt_0, bus.gnt_1, exp_g[i]);
      end
      tick(exp_g[i]);
    end
    idle();
    tick(-1);
    tick(-1);
  endtask
  task automatic test_lock_cap();
    int g;
    set_req(0, 1, 0, 0, 3'b001, 12'h200, '0);
    for (int i = 0; i < 22; i++) begin
      g = (i == 16) ? 0 : 1;
      set_req(1, 1, i != 21, 1, 3'b011, 12'h100 + AW'(i), DW'(i) + 20'h70000);
      #1;
      n_chk++;
      if ({bus.gnt_0, bus.gnt_1} !== {g == 0, g == 1}) begin
        n_fail++; $display("FAIL cap_gnt[%0d] got %b%b want idx %0d", i, bus.gnt_0, bus.gnt_1, g);
      end
      tick(g);
      if (g == 0) set_req(0, 0, 0, 0, 3'b000, '0, '0);
    end
    idle();
    tick(-1);
    tick(-1);
  endtask
  task automatic test_sel_passthrough();
    set_req(0, 1, 0, 1, 3'b101, 12'h0F0, 20'h12345);
    #1;
    n_chk++;
    if (bus.gnt_0 !== 1'b1) begin
      n_fail++; $display("FAIL sel_gnt0 got %b want 1", bus.gnt_0);
    end
    tick(0);
    idle();
    set_req(1, 1, 0, 0, 3'b111, 12'h0F0, '0);
    #1;
    n_chk++;
    if (bus.gnt_1 !== 1'b1) begin
      n_fail++; $display("FAIL sel_gnt1 got %b want 1", bus.gnt_1);
    end
    tick(1);
    idle();
    n_chk++;
    if (bus.csel !== 3'b111) begin
      n_fail++; $display("FAIL sel_pass got %b want 111", bus.csel);
    end
    tick(-1);
    tick(-1);
  endtask
  task automatic test_reset_mid_read();
    set_req(0, 1, 0, 0, 3'b001, 12'h005, '0);
    #1;
    tick(0);
    rd_q.delete();
    reset = 1'b1;
    set_req(0, 1, 0, 0, 3'b001, 12'h006, '0);
    set_req(1, 1, 0, 0, 3'b011, 12'h007, '0);
    #1;
    n_chk++;
    if ({bus.gnt_0, bus.gnt_1} !== 2'b00) begin
      n_fail++; $display("FAIL mid_rst_gnt got %b%b want 00", bus.gnt_0, bus.gnt_1);
    end
    tick(-1);
    reset = 1'b0;
    n_chk++;
    if ({bus.rvalid_0, bus.rvalid_1, bus.cwr, bus.crd} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_rst_out got v0=%b v1=%b wr=%b rd=%b want 0000", bus.rvalid_0, bus.rvalid_1, bus.cwr, bus.crd);
    end
    #1;
    n_chk++;
    if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin
      n_fail++; $display("FAIL mid_rst_tie got %b%b want 10", bus.gnt_0, bus.gnt_1);
    end
    tick(0);
    idle();
    tick(-1);
    tick(-1);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = DW'(i * 7 + 3);
      exp_mem[i] = DW'(i * 7 + 3);
    end
    idle();
    @(negedge clk);
    test_reset();
    test_single_write();
    test_read_latency();
    test_wr_then_rd();
    test_round_robin();
    test_lock();
    test_lock_cap();
    test_sel_passthrough();
    test_reset_mid_read();
    tick(-1);
    n_chk++;
    if (cmd_q.size() + rd_q.size() != 0) begin
      n_fail++; $display("FAIL drain got %0d pending want 0", cmd_q.size() + rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
